cdb_arbiter: RTL and testbench

- Consumer end of the FU-to-CDB request/ack protocol. Sits between the functional-unit wrappers (ALU, FPU, LSU) and the Common Data Bus.
- Each cycle it picks at most one requesting FU, returns a same-cycle ack to it, and broadcasts the winner's result, tag and destination register on the CDB one cycle later.
- Ports listed in a mask cannot hold their requests, for example single-cycle MUL/DIV done pulses. These ports get fixed priority. All other ports share the bus round-robin.

---
 rtl/cdb_arbiter.sv | 116 +++++++++++
 tb/tb_cdb_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: fixed priority for non-holdable FU ports, round-robin for the rest.
// Same-cycle combinational ack; the winner's payload is broadcast one cycle later.
module cdb_arbiter #(
  parameter int N_FU       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter logic [N_FU-1:0] PRIO_MASK = {{(N_FU-1){1'b0}}, 1'b1}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_FU-1:0]           req_valid,
  input  logic [N_FU*DATA_WIDTH-1:0] req_result,
  input  logic [N_FU*TAG_WIDTH-1:0] req_tag,
  input  logic [N_FU*5-1:0]         req_dest,
  output logic [N_FU-1:0]           req_ack,
  output logic                      cdb_valid,
  output logic [DATA_WIDTH-1:0]     cdb_result,
  output logic [TAG_WIDTH-1:0]      cdb_tag,
  output logic [4:0]                cdb_dest_reg,
  output logic                      prio_conflict,
  output logic [15:0]               bcast_cnt
);

  localparam int PTR_W = $clog2(N_FU);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  cdb_valid_q;
  logic [DATA_WIDTH-1:0] cdb_result_q;
  logic [TAG_WIDTH-1:0]  cdb_tag_q;
  logic [4:0]            cdb_dest_q;
  logic                  prio_conflict_q;
  logic [15:0]           bcast_cnt_q;

  logic [N_FU-1:0]       prio_req;
  logic [N_FU-1:0]       ack_d;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  grant_rr;
  logic                  conflict_d;
  int                    j;
  int                    sel;

  always_comb begin
    ack_d     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    grant_rr  = 1'b0;
    j         = 0;
    prio_req  = req_valid & PRIO_MASK;
    if (!rst && !flush) begin
      if (|prio_req) begin
        // Descending scan so the lowest requesting priority index wins last.
        for (int i = N_FU - 1; i >= 0; i--) begin
          if (prio_req[i]) begin
            grant_idx = PTR_W'(i);
            grant_any = 1'b1;
          end
        end
      end else begin
        // Descending offset scan: the port closest to rr_ptr overwrites the others.
        for (int k = N_FU - 1; k >= 0; k--) begin
          j = int'(rr_ptr_q) + k;
          if (j >= N_FU) j = j - N_FU;
          if (req_valid[j]) begin
            grant_idx = PTR_W'(j);
            grant_any = 1'b1;
            grant_rr  = 1'b1;
          end
        end
      end
    end
    if (grant_any) ack_d[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_rr) begin
      rr_ptr_d = (grant_idx == PTR_W'(N_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign sel        = int'(grant_idx);
  assign conflict_d = !rst && !flush && |(prio_req & ~ack_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      cdb_valid_q     <= 1'b0;
      cdb_result_q    <= '0;
      cdb_tag_q       <= '0;
      cdb_dest_q      <= '0;
      prio_conflict_q <= 1'b0;
      bcast_cnt_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant_any;
      if (grant_any) begin
        cdb_result_q <= req_result[sel*DATA_WIDTH +: DATA_WIDTH];
        cdb_tag_q    <= req_tag[sel*TAG_WIDTH +: TAG_WIDTH];
        cdb_dest_q   <= req_dest[sel*5 +: 5];
        bcast_cnt_q  <= bcast_cnt_q + 16'd1;
      end
      if (conflict_d) prio_conflict_q <= 1'b1;
    end
  end

  assign req_ack       = ack_d;
  assign cdb_valid     = cdb_valid_q;
  assign cdb_result    = cdb_result_q;
  assign cdb_tag       = cdb_tag_q;
  assign cdb_dest_reg  = cdb_dest_q;
  assign prio_conflict = prio_conflict_q;
  assign bcast_cnt     = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus sequences for conflict, reset and counter wrap.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        flush, flush2;
  logic [3:0]  rv, rv2;
  logic [127:0] res_bus;
  logic [11:0] tag_bus;
  logic [19:0] dest_bus;

  logic [3:0]  ack, ack2;
  logic        vld, vld2;
  logic [31:0] res, res2;
  logic [2:0]  tag, tag2;
  logic [4:0]  dst, dst2;
  logic        pc, pc2;
  logic [15:0] cnt, cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_FU(4), .DATA_WIDTH(32), .TAG_WIDTH(3), .PRIO_MASK(4'b0001)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(rv),
    .req_result(res_bus), .req_tag(tag_bus), .req_dest(dest_bus),
    .req_ack(ack), .cdb_valid(vld), .cdb_result(res), .cdb_tag(tag),
    .cdb_dest_reg(dst), .prio_conflict(pc), .bcast_cnt(cnt));

  cdb_arbiter #(.N_FU(4), .DATA_WIDTH(32), .TAG_WIDTH(3), .PRIO_MASK(4'b0011)) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .req_valid(rv2),
    .req_result(res_bus), .req_tag(tag_bus), .req_dest(dest_bus),
    .req_ack(ack2), .cdb_valid(vld2), .cdb_result(res2), .cdb_tag(tag2),
    .cdb_dest_reg(dst2), .prio_conflict(pc2), .bcast_cnt(cnt2));

  // Expected {result, tag, dest} of each port; -1 is the post-reset zero payload.
  function automatic logic [39:0] pay(input int src);
    case (src)
      0:       return {32'h1111_0000, 3'd1, 5'd3};
      1:       return {32'h2222_0001, 3'd2, 5'd9};
      2:       return {32'hDEADBEEF,  3'd5, 5'd7};
      3:       return {32'h4444_0003, 3'd0, 5'd0};
      default: return 40'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic        fl;
    logic [3:0]  ack;
    logic        vld;
    int          src;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec[15];

  initial begin
    // rv, flush | ack this cycle, cdb_valid/payload source/bcast_cnt seen this cycle
    vec[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 16'd0};
    vec[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, -1, 16'd0};
    vec[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1,  2, 16'd1};
    vec[3]  = '{4'b1000, 1'b0, 4'b1000, 1'b0,  2, 16'd1};
    vec[4]  = '{4'b1110, 1'b0, 4'b0010, 1'b1,  3, 16'd2};
    vec[5]  = '{4'b1110, 1'b0, 4'b0100, 1'b1,  1, 16'd3};
    vec[6]  = '{4'b1110, 1'b0, 4'b1000, 1'b1,  2, 16'd4};
    vec[7]  = '{4'b1110, 1'b0, 4'b0010, 1'b1,  3, 16'd5};
    vec[8]  = '{4'b0101, 1'b0, 4'b0001, 1'b1,  1, 16'd6};
    vec[9]  = '{4'b0110, 1'b0, 4'b0100, 1'b1,  0, 16'd7};
    vec[10] = '{4'b1111, 1'b1, 4'b0000, 1'b1,  2, 16'd8};
    vec[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0,  2, 16'd8};
    vec[12] = '{4'b1010, 1'b0, 4'b1000, 1'b0,  2, 16'd8};
    vec[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1,  3, 16'd9};
    vec[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0,  3, 16'd9};

    res_bus  = {32'h4444_0003, 32'hDEADBEEF, 32'h2222_0001, 32'h1111_0000};
    tag_bus  = {3'd0, 3'd5, 3'd2, 3'd1};
    dest_bus = {5'd0, 5'd7, 5'd9, 5'd3};

    rst = 1'b1; rst2 = 1'b1; flush = 1'b0; flush2 = 1'b0;
    rv = 4'b1111; rv2 = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_vld", 64'(vld), 64'd0);
    chk("reset_payload", 64'({res, tag, dst}), 64'd0);
    chk("reset_conflict", 64'(pc), 64'd0);
    chk("reset_cnt", 64'(cnt), 64'd0);
    rst = 1'b0; rst2 = 1'b0; rv = 4'b0000; rv2 = 4'b0000;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rv = vec[i].rv; flush = vec[i].fl;
      #1;
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vec[i].ack));
      chk($sformatf("v%0d_vld", i), 64'(vld), 64'(vec[i].vld));
      chk($sformatf("v%0d_payload", i), 64'({res, tag, dst}), 64'(pay(vec[i].src)));
      chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vec[i].cnt));
    end
    flush = 1'b0;
    chk("no_conflict_mask0001", 64'(pc), 64'd0);

    // Two priority ports together on the 0011 instance: sticky conflict flag.
    @(negedge clk);
    rv2 = 4'b0011; #1;
    chk("conf_ack", 64'(ack2), 64'b0001);
    chk("conf_before_edge", 64'(pc2), 64'd0);
    @(negedge clk);
    rv2 = 4'b0000; #1;
    chk("conf_set", 64'(pc2), 64'd1);
    chk("conf_bcast", 64'({vld2, res2, tag2, dst2}), 64'({1'b1, pay(0)}));
    repeat (10) @(negedge clk);
    #1;
    chk("conf_sticky", 64'(pc2), 64'd1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; #1;
    chk("conf_cleared", 64'(pc2), 64'd0);

    // Reset discards a broadcast that was loaded and forces ack low.
    rv = 4'b0100;
    @(negedge clk); #1;
    chk("pre_rst_vld", 64'(vld), 64'd1);
    chk("pre_rst_cnt", 64'(cnt), 64'd10);
    rst = 1'b1; #1;
    chk("rst_forces_ack", 64'(ack), 64'd0);
    @(negedge clk);
    rst = 1'b0; rv = 4'b1010; #1;
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_payload", 64'({res, tag, dst}), 64'd0);
    chk("rst_rr_ptr0", 64'(ack), 64'b0010);

    // Counter wrap: port 1 grant above gives 1; hold port 0 for 65534 more grants.
    @(negedge clk);
    rv = 4'b0001;
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    chk("cnt_ffff", 64'(cnt), 64'hFFFF);
    @(negedge clk);
    rv = 4'b0000; #1;
    chk("cnt_wrap", 64'(cnt), 64'd0);
    chk("wrap_vld", 64'(vld), 64'd1);
    @(negedge clk); #1;
    chk("wrap_idle_vld", 64'(vld), 64'd0);
    chk("wrap_idle_cnt", 64'(cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
